input_debouncer: RTL and testbench

- Conditions a raw asynchronous level input (push button, DIP switch, external strobe) into a clean, glitch-free level in the `clk` domain.
- Sits directly upstream of the edge-detect stage (`one_shot`). Its `out_level` drives that stage's `in`, which turns each debounced transition into a single-cycle pulse.
- Pipeline: 2-flop synchronizer, then a counter-based stability filter controlled by a 4-state FSM.

---
 rtl/input_debouncer_pkg.sv | 19 +
 rtl/sync_2ff.sv | 27 ++
 rtl/input_debouncer.sv | 112 +++++++++++
 tb/tb_input_debouncer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/input_debouncer_pkg.sv
// Shared constants and FSM encodings for the input conditioning stages.
// Also used by the downstream edge-detect stage.
package input_debouncer_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        RISE_WAIT = 2'd1,
        IDLE_HIGH = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    function automatic state_t idle_for(input logic lvl);
        return lvl ? IDLE_HIGH : IDLE_LOW;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level input.
// Reusable for any async input; no logic between the flops.
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic r_s1;
    logic r_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= RESET_VALUE;
            r_s2 <= RESET_VALUE;
        end else begin
            r_s1 <= d;
            r_s2 <= r_s1;
        end
    end

    assign q = r_s2;

endmodule

// File: rtl/input_debouncer.sv
// Debounces a raw async level: 2-flop sync, then a counter-timed
// stability filter so out_level only follows a held input.
module input_debouncer
    import input_debouncer_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter logic        INIT_LEVEL    = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in,
    output logic out_level,
    output logic settling
);

    localparam int unsigned COUNTER_WIDTH = $clog2(STABLE_CYCLES) + 1;

    typedef logic [COUNTER_WIDTH-1:0] count_t;

    localparam count_t LAST   = count_t'(STABLE_CYCLES - 1);
    localparam count_t ONE    = count_t'(1);
    localparam logic   SINGLE = (STABLE_CYCLES == 1);

    logic   w_in_sync;
    state_t r_state;
    count_t r_count;
    logic   r_out_level;
    logic   r_settling;

    sync_2ff #(
        .RESET_VALUE(INIT_LEVEL)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (in),
        .q      (w_in_sync)
    );

    // Any reversal during a WAIT state discards the candidate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= idle_for(INIT_LEVEL);
            r_count     <= '0;
            r_out_level <= INIT_LEVEL;
            r_settling  <= FALSE;
        end else begin
            case (r_state)
                IDLE_LOW: begin
                    if (w_in_sync == TRUE) begin
                        if (SINGLE) begin
                            r_state     <= IDLE_HIGH;
                            r_out_level <= TRUE;
                        end else begin
                            r_state    <= RISE_WAIT;
                            r_count    <= ONE;
                            r_settling <= TRUE;
                        end
                    end
                end
                RISE_WAIT: begin
                    if (w_in_sync == FALSE) begin
                        r_state    <= IDLE_LOW;
                        r_count    <= '0;
                        r_settling <= FALSE;
                    end else if (r_count == LAST) begin
                        r_state     <= IDLE_HIGH;
                        r_out_level <= TRUE;
                        r_count     <= '0;
                        r_settling  <= FALSE;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (w_in_sync == FALSE) begin
                        if (SINGLE) begin
                            r_state     <= IDLE_LOW;
                            r_out_level <= FALSE;
                        end else begin
                            r_state    <= FALL_WAIT;
                            r_count    <= ONE;
                            r_settling <= TRUE;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (w_in_sync == TRUE) begin
                        r_state    <= IDLE_HIGH;
                        r_count    <= '0;
                        r_settling <= FALSE;
                    end else if (r_count == LAST) begin
                        r_state     <= IDLE_LOW;
                        r_out_level <= FALSE;
                        r_count     <= '0;
                        r_settling  <= FALSE;
                    end else begin
                        r_count <= r_count + ONE;
                    end
                end
                default: begin
                    r_state    <= idle_for(r_out_level);
                    r_count    <= '0;
                    r_settling <= FALSE;
                end
            endcase
        end
    end

    assign out_level = r_out_level;
    assign settling  = r_settling;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: vector table, corner sequences,
// and random bursts against a run-length reference model.
module tb_input_debouncer;

    logic clk = 1'b0;
    logic reset_n;
    logic in0, in1;
    logic out0, set0, out1, set1;

    always #5 clk = ~clk;

    input_debouncer #(
        .STABLE_CYCLES(4),
        .INIT_LEVEL   (1'b0)
    ) u_dut0 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in0),
        .out_level(out0),
        .settling (set0)
    );

    input_debouncer #(
        .STABLE_CYCLES(1),
        .INIT_LEVEL   (1'b1)
    ) u_dut1 (
        .clk      (clk),
        .reset_n  (reset_n),
        .in       (in1),
        .out_level(out1),
        .settling (set1)
    );

    typedef struct {
        logic in;
        logic out;
        logic set;
    } vec_t;

    vec_t tbl[26];
    logic pat[5];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_model = 1'b0;

    // Reference: out follows the input seen two edges earlier once it
    // has disagreed with out for STABLE consecutive edges.
    logic m_d1[2], m_d2[2], m_out[2], m_init[2];
    int   m_run[2], m_stab[2];

    function automatic vec_t v(input logic i, input logic o, input logic s);
        vec_t r;
        r.in  = i;
        r.out = o;
        r.set = s;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_d1[k]  = m_init[k];
            m_d2[k]  = m_init[k];
            m_out[k] = m_init[k];
            m_run[k] = 0;
        end
    endtask

    task automatic model_step(input int k, input logic val);
        logic sees;
        sees    = m_d2[k];
        m_d2[k] = m_d1[k];
        m_d1[k] = val;
        if (sees != m_out[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] >= m_stab[k]) begin
            m_out[k] = sees;
            m_run[k] = 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        if (reset_n) begin
            model_step(0, in0);
            model_step(1, in1);
        end
        #1;
        if (chk_model) begin
            check("mdl_out0", int'(out0), int'(m_out[0]));
            check("mdl_set0", int'(set0), int'(m_run[0] != 0));
            check("mdl_out1", int'(out1), int'(m_out[1]));
            check("mdl_set1", int'(set1), int'(m_run[1] != 0));
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int rises;
        logic prev;
        int len0, len1;

        m_init[0] = 1'b0; m_stab[0] = 4;
        m_init[1] = 1'b1; m_stab[1] = 1;

        tbl[0]  = v(0, 0, 0); tbl[1]  = v(0, 0, 0);
        tbl[2]  = v(1, 0, 0); tbl[3]  = v(1, 0, 0);
        tbl[4]  = v(1, 0, 1); tbl[5]  = v(1, 0, 1);
        tbl[6]  = v(1, 0, 1); tbl[7]  = v(1, 1, 0);
        tbl[8]  = v(0, 1, 0); tbl[9]  = v(0, 1, 0);
        tbl[10] = v(0, 1, 1); tbl[11] = v(1, 1, 1);
        tbl[12] = v(1, 1, 1); tbl[13] = v(1, 1, 0);
        tbl[14] = v(1, 1, 0); tbl[15] = v(0, 1, 0);
        tbl[16] = v(0, 1, 0); tbl[17] = v(0, 1, 1);
        tbl[18] = v(0, 1, 1); tbl[19] = v(1, 1, 1);
        tbl[20] = v(1, 0, 0); tbl[21] = v(1, 0, 1);
        tbl[22] = v(1, 0, 1); tbl[23] = v(1, 0, 1);
        tbl[24] = v(1, 1, 0); tbl[25] = v(1, 1, 0);

        pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b1;
        pat[3] = 1'b0; pat[4] = 1'b1;

        // Reset held with input high, then release
        reset_n = 1'b0;
        in0 = 1'b1;
        in1 = 1'b1;
        model_reset();
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rst_out0", int'(out0), 0);
            check("rst_set0", int'(set0), 0);
            check("rst_out1", int'(out1), 1);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check($sformatf("rel_out0[%0d]", i), int'(out0), int'(i == 6));
            check($sformatf("rel_set0[%0d]", i), int'(set0), int'(i >= 3 && i <= 5));
        end

        // Vector table: clean rise, 3-cycle glitch, 4-cycle boundary
        in0 = 1'b0;
        do_reset();
        for (int i = 0; i < 26; i++) begin
            in0 = tbl[i].in;
            cycle();
            check($sformatf("tbl_out[%0d]", i), int'(out0), int'(tbl[i].out));
            check($sformatf("tbl_set[%0d]", i), int'(set0), int'(tbl[i].set));
        end

        // Bounce 1,0,1,0,1 then hold high
        in0 = 1'b0;
        do_reset();
        repeat (2) cycle();
        rises = 0;
        prev = out0;
        for (int i = 0; i < 14; i++) begin
            in0 = (i < 5) ? pat[i] : 1'b1;
            cycle();
            if (out0 && !prev) rises++;
            prev = out0;
            if (i == 8) check("bounce_early", int'(out0), 0);
            if (i == 9) check("bounce_rise", int'(out0), 1);
        end
        check("bounce_rises", rises, 1);

        // Reset asserted during RISE_WAIT at count 2
        in0 = 1'b0;
        do_reset();
        repeat (2) cycle();
        in0 = 1'b1;
        repeat (4) cycle();
        check("midwait_set", int'(set0), 1);
        reset_n = 1'b0;
        model_reset();
        #1;
        check("midwait_out", int'(out0), 0);
        check("midwait_set0", int'(set0), 0);
        @(posedge clk);
        #1;
        check("midwait_hold", int'(out0), 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            cycle();
            check($sformatf("midwait_req[%0d]", i), int'(out0), int'(i == 6));
        end

        // STABLE_CYCLES=1, INIT_LEVEL=1 instance
        in1 = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check($sformatf("s1_fall[%0d]", i), int'(out1), int'(i < 3));
            check($sformatf("s1_set[%0d]", i), int'(set1), 0);
        end
        in1 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            cycle();
            check($sformatf("s1_rise[%0d]", i), int'(out1), int'(i == 3));
            check($sformatf("s1_setr[%0d]", i), int'(set1), 0);
        end

        // Random bursts against the reference model
        do_reset();
        chk_model = 1'b1;
        len0 = 0;
        len1 = 0;
        for (int n = 0; n < 3000; n++) begin
            if (len0 == 0) begin
                in0  = 1'($urandom_range(0, 1));
                len0 = $urandom_range(1, 9);
            end
            if (len1 == 0) begin
                in1  = 1'($urandom_range(0, 1));
                len1 = $urandom_range(1, 4);
            end
            len0--;
            len1--;
            if ($urandom_range(0, 299) == 0) begin
                reset_n = 1'b0;
                model_reset();
                #1;
                check("rnd_rst_out0", int'(out0), 0);
                check("rnd_rst_out1", int'(out1), 1);
                check("rnd_rst_set0", int'(set0), 0);
                @(negedge clk);
                reset_n = 1'b1;
            end
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
